// File: rtl/gray_ptr_sync.sv
// Gray-coded pointer receiver: multi-flop synchroniser, Gray->binary conversion,
// change detection with step size. Optional illegal-jump flag: GRAY_ERR_CHECK_EN.
module gray_ptr_sync #(
  parameter int WIDTH       = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] gray_in,
  input  logic             err_clr,
  output logic [WIDTH-1:0] gray_sync,
  output logic [WIDTH-1:0] bin_out,
  output logic [WIDTH-1:0] delta,
  output logic             valid,
  output logic             err
);

  localparam int CNT_W = $clog2(SYNC_STAGES);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(SYNC_STAGES - 1);

  typedef enum logic {
    FILL  = 1'b0,
    TRACK = 1'b1
  } state_t;

  logic [WIDTH-1:0] r_sync [SYNC_STAGES];
  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_prev;
  logic [WIDTH-1:0] r_bin;
  logic [WIDTH-1:0] r_delta;
  logic             r_valid;

  logic [WIDTH-1:0] w_gray_sync;
  logic [WIDTH-1:0] w_sync_next;
  logic [WIDTH-1:0] w_bin_new;
  logic             w_change;

  function automatic logic [WIDTH-1:0] g2b(input logic [WIDTH-1:0] g);
    logic [WIDTH-1:0] b;
    b = '0;
    b[WIDTH-1] = g[WIDTH-1];
    for (int i = WIDTH - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  assign w_gray_sync = r_sync[SYNC_STAGES-1];
  // Baseline is taken from the value entering the chain output on the capture
  // edge, so gray_prev matches gray_sync once TRACK starts and no spurious pulse fires.
  assign w_sync_next = r_sync[SYNC_STAGES-2];
  assign w_bin_new   = g2b(w_gray_sync);
  assign w_change    = (w_gray_sync != r_prev);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        r_sync[i] <= '0;
      end
      r_state <= FILL;
      r_cnt   <= '0;
      r_prev  <= '0;
      r_bin   <= '0;
      r_delta <= '0;
      r_valid <= 1'b0;
    end else begin
      r_sync[0] <= gray_in;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        r_sync[i] <= r_sync[i-1];
      end
      case (r_state)
        FILL: begin
          r_valid <= 1'b0;
          if (r_cnt == LAST_CNT) begin
            r_prev  <= w_sync_next;
            r_bin   <= g2b(w_sync_next);
            r_state <= TRACK;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        TRACK: begin
          if (w_change) begin
            r_prev  <= w_gray_sync;
            r_bin   <= w_bin_new;
            r_delta <= w_bin_new - r_bin;
            r_valid <= 1'b1;
          end else begin
            r_valid <= 1'b0;
          end
        end
        default: begin
          r_state <= FILL;
          r_cnt   <= '0;
          r_valid <= 1'b0;
        end
      endcase
    end
  end

`ifdef GRAY_ERR_CHECK_EN
  logic [WIDTH-1:0] w_gdiff;
  logic             w_multi;
  logic             r_err;

  assign w_gdiff = w_gray_sync ^ r_prev;
  // More than one bit set <=> clearing the lowest set bit leaves something.
  assign w_multi = ((w_gdiff & (w_gdiff - WIDTH'(1))) != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err <= 1'b0;
    end else if ((r_state == TRACK) && w_change && w_multi) begin
      r_err <= 1'b1;
    end else if (err_clr) begin
      r_err <= 1'b0;
    end
  end

  assign err = r_err;
`else
  logic w_unused_err_clr;
  assign w_unused_err_clr = err_clr;
  assign err = 1'b0;
`endif

  assign gray_sync = w_gray_sync;
  assign bin_out   = r_bin;
  assign delta     = r_delta;
  assign valid     = r_valid;

endmodule

// File: tb/tb_gray_ptr_sync.sv
// Bench for gray_ptr_sync (WIDTH=4, SYNC_STAGES=2): directed vector table,
// hand-written reset sequences and random traffic against a history-based model.
module tb_gray_ptr_sync;

  localparam int W    = 4;
  localparam int SS   = 2;
  localparam int HOLD = 5;
`ifdef GRAY_ERR_CHECK_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst_n;
  logic [W-1:0] gray_in;
  logic         err_clr;
  logic [W-1:0] gray_sync;
  logic [W-1:0] bin_out;
  logic [W-1:0] delta;
  logic         valid;
  logic         err;

  gray_ptr_sync #(.WIDTH(W), .SYNC_STAGES(SS)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .gray_in   (gray_in),
    .err_clr   (err_clr),
    .gray_sync (gray_sync),
    .bin_out   (bin_out),
    .delta     (delta),
    .valid     (valid),
    .err       (err)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  // Reference model: every value sampled since reset release is kept, so the
  // synchronised view is simply the sample taken SS edges ago.
  logic [W-1:0] hist[$];
  logic [W-1:0] m_gsync, m_prev, m_bin, m_delta;
  logic         m_valid, m_err;

  function automatic logic [W-1:0] bin_of(input logic [W-1:0] g);
    for (int i = 0; i < (1 << W); i++) begin
      if (W'(i ^ (i >> 1)) == g) return W'(i);
    end
    return '0;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    hist.delete();
    m_gsync = '0; m_prev = '0; m_bin = '0; m_delta = '0;
    m_valid = 1'b0; m_err = 1'b0;
  endtask

  task automatic model_edge();
    int           e;
    logic [W-1:0] old_gs;
    bit           set_err;
    e       = hist.size();
    old_gs  = (e >= SS) ? hist[e-SS] : '0;
    hist.push_back(gray_in);
    e       = e + 1;
    set_err = 1'b0;
    if (e == SS) begin
      m_prev  = hist[0];
      m_bin   = bin_of(hist[0]);
      m_valid = 1'b0;
    end else if (e > SS) begin
      if (old_gs != m_prev) begin
        m_delta = W'(bin_of(old_gs) - m_bin);
        m_bin   = bin_of(old_gs);
        set_err = ERR_EN && ($countones(old_gs ^ m_prev) > 1);
        m_prev  = old_gs;
        m_valid = 1'b1;
      end else begin
        m_valid = 1'b0;
      end
    end else begin
      m_valid = 1'b0;
    end
    if (set_err) m_err = 1'b1;
    else if (ERR_EN && err_clr) m_err = 1'b0;
    m_gsync = (e >= SS) ? hist[e-SS] : '0;
  endtask

  task automatic check_all();
    chk("gray_sync", 32'(gray_sync), 32'(m_gsync));
    chk("bin_out",   32'(bin_out),   32'(m_bin));
    chk("delta",     32'(delta),     32'(m_delta));
    chk("valid",     32'(valid),     32'(m_valid));
    chk("err",       32'(err),       32'(m_err));
  endtask

  task automatic step();
    @(posedge clk);
    if (rst_n) model_edge();
    @(negedge clk);
    check_all();
  endtask

  // Asserts reset between clock edges, checks the asynchronous clear, then
  // releases on a falling edge with gray_in = g.
  task automatic apply_reset(input logic [W-1:0] g);
    #2;
    rst_n   = 1'b0;
    gray_in = g;
    err_clr = 1'b0;
    model_reset();
    #1;
    check_all();
    step();
    step();
    rst_n = 1'b1;
  endtask

  typedef struct {
    bit           rst;
    logic [W-1:0] g;
    int           clr_at;
    int           pulses;
    logic [W-1:0] bin;
    logic [W-1:0] dlt;
    bit           errm;
  } vec_t;

  vec_t tbl[10];

  initial begin
    int pulses;
    int pulse_at;
    int vcnt;
    int r;

    tbl[0] = '{1'b1, 4'b0000, -1, 0, 4'b0000, 4'b0000, 1'b0};
    tbl[1] = '{1'b0, 4'b0001, -1, 1, 4'b0001, 4'b0001, 1'b0};
    tbl[2] = '{1'b0, 4'b0011, -1, 1, 4'b0010, 4'b0001, 1'b0};
    tbl[3] = '{1'b0, 4'b0010, -1, 1, 4'b0011, 4'b0001, 1'b0};
    tbl[4] = '{1'b1, 4'b1001, -1, 0, 4'b1110, 4'b0000, 1'b0};
    tbl[5] = '{1'b0, 4'b1000, -1, 1, 4'b1111, 4'b0001, 1'b0};
    tbl[6] = '{1'b0, 4'b0000, -1, 1, 4'b0000, 4'b0001, 1'b0};
    tbl[7] = '{1'b0, 4'b0011, -1, 1, 4'b0010, 4'b0010, 1'b1};
    tbl[8] = '{1'b0, 4'b0011,  0, 0, 4'b0010, 4'b0010, 1'b0};
    tbl[9] = '{1'b0, 4'b0000,  2, 1, 4'b0000, 4'b1110, 1'b1};

    rst_n   = 1'b0;
    gray_in = 4'b0110;
    err_clr = 1'b0;
    model_reset();

    // Baseline after reset release: no pulse, bin_out = g2b(0110)
    apply_reset(4'b0110);
    vcnt = 0;
    step(); if (valid) vcnt++;
    step(); if (valid) vcnt++;
    chk("base_bin", 32'(bin_out), 32'(4'b0100));
    chk("base_delta", 32'(delta), 32'(4'b0000));
    chk("base_err", 32'(err), 32'(1'b0));
    for (int i = 0; i < 4; i++) begin
      step(); if (valid) vcnt++;
    end
    chk("base_no_valid", 32'(vcnt), 32'(0));

    for (int v = 0; v < 10; v++) begin
      if (tbl[v].rst) apply_reset(tbl[v].g);
      else gray_in = tbl[v].g;
      pulses   = 0;
      pulse_at = -1;
      for (int c = 0; c < HOLD; c++) begin
        err_clr = (c == tbl[v].clr_at);
        step();
        if (valid) begin
          pulses++;
          pulse_at = c;
        end
      end
      err_clr = 1'b0;
      chk($sformatf("vec%0d_pulses", v), 32'(pulses), 32'(tbl[v].pulses));
      chk($sformatf("vec%0d_latency", v), 32'(pulse_at), 32'((tbl[v].pulses != 0) ? 2 : -1));
      chk($sformatf("vec%0d_bin", v), 32'(bin_out), 32'(tbl[v].bin));
      chk($sformatf("vec%0d_delta", v), 32'(delta), 32'(tbl[v].dlt));
      chk($sformatf("vec%0d_err", v), 32'(err), 32'(ERR_EN ? tbl[v].errm : 1'b0));
    end

    // Back-to-back single-bit changes give consecutive pulses
    gray_in = 4'b0001; step();
    gray_in = 4'b0011; step();
    gray_in = 4'b0010; step();
    vcnt = 0;
    for (int i = 0; i < 4; i++) begin
      step(); if (valid) vcnt++;
    end
    chk("b2b_pulses", 32'(vcnt), 32'(2));
    chk("b2b_bin", 32'(bin_out), 32'(4'b0011));

    // Mid-stream reset: asynchronous clear, warm-up repeats without a pulse
    apply_reset(4'b0010);
    chk("mid_rst_bin", 32'(bin_out), 32'(0));
    vcnt = 0;
    for (int i = 0; i < 6; i++) begin
      step(); if (valid) vcnt++;
    end
    chk("mid_rst_no_valid", 32'(vcnt), 32'(0));
    chk("mid_rst_bin_after", 32'(bin_out), 32'(4'b0011));
    chk("mid_rst_err", 32'(err), 32'(1'b0));

    // Random traffic: mostly legal Gray steps, some jumps, clears and resets
    for (int i = 0; i < 3000; i++) begin
      r = int'($urandom_range(0, 99));
      err_clr = ($urandom_range(0, 15) == 0);
      if (r < 2) begin
        apply_reset(W'($urandom_range(0, 15)));
      end else if (r < 50) begin
        gray_in = gray_in ^ W'(1 << $urandom_range(0, W-1));
      end else if (r < 56) begin
        gray_in = W'($urandom_range(0, 15));
      end
      step();
    end
    err_clr = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
